// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one unsigned multiplier, optional MULT_ARB_SAT_EN saturation
module mult_arbiter #(
    parameter int ENTRY_SIZE    = 5,
    parameter int RESENTRY_SIZE = 9,
    parameter int NUM_REQ       = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ENTRY_SIZE-1:0] req_a,
    input  logic [NUM_REQ*ENTRY_SIZE-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [RESENTRY_SIZE-1:0]      rsp_result
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = 2 * ENTRY_SIZE;
    localparam int WW  = (PW > RESENTRY_SIZE) ? PW : RESENTRY_SIZE;

    logic [IDW-1:0]           ptr_q, ptr_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]           rsp_id_q, rsp_id_d;
    logic [RESENTRY_SIZE-1:0] rsp_result_q, rsp_result_d;

    logic                     gnt_found;
    logic [IDW-1:0]           gnt_idx;
    logic [NUM_REQ-1:0]       grant;
    logic                     slot_free;
    logic                     handshake;
    logic [ENTRY_SIZE-1:0]    sel_a, sel_b;
    logic [WW-1:0]            prod_wide;
    logic [RESENTRY_SIZE-1:0] prod_res;

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

    assign grant     = gnt_found ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign slot_free = !rsp_valid_q || rsp_ready;
    // Held low during reset so nothing is accepted while state is being cleared.
    assign req_ready = (reset_n && slot_free) ? grant : '0;
    assign handshake = |(req_valid & req_ready);

    // Operands come straight from this cycle's inputs of the granted requester.
    assign sel_a     = req_a[int'(gnt_idx)*ENTRY_SIZE +: ENTRY_SIZE];
    assign sel_b     = req_b[int'(gnt_idx)*ENTRY_SIZE +: ENTRY_SIZE];
    assign prod_wide = WW'(sel_a) * WW'(sel_b);

`ifdef MULT_ARB_SAT_EN
    logic overflow;
    assign overflow = |(prod_wide >> RESENTRY_SIZE);
    assign prod_res = overflow ? '1 : RESENTRY_SIZE'(prod_wide);
`else
    assign prod_res = RESENTRY_SIZE'(prod_wide);
`endif

    // Next-state: load on handshake, drop valid once consumed, otherwise hold.
    always_comb begin
        ptr_d        = ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        if (handshake) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gnt_idx;
            rsp_result_d = prod_res;
            ptr_d        = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // State registers; reset discards any pending result and restarts the search at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - table-driven scoreboard bench for mult_arbiter
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [19:0] req_a;
    logic [19:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [8:0]  rsp_result;

    mult_arbiter #(.ENTRY_SIZE(5), .RESENTRY_SIZE(9), .NUM_REQ(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [8:0] res;
    } exp_t;

    typedef struct {
        logic [3:0]  v;
        logic [19:0] a;
        logic [19:0] b;
        logic        rr;
        logic [3:0]  er;
    } vec_t;

    exp_t q[$];
    vec_t vt[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [19:0] pk(input int x3, input int x2, input int x1, input int x0);
        return {5'(x3), 5'(x2), 5'(x1), 5'(x0)};
    endfunction

    function automatic logic [8:0] prod(input logic [4:0] a, input logic [4:0] b);
        logic [9:0] full;
        full = 10'(a) * 10'(b);
`ifdef MULT_ARB_SAT_EN
        return (full > 10'd511) ? 9'd511 : full[8:0];
`else
        return full[8:0];
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [19:0] a, input logic [19:0] b,
                       input logic rr, input logic [3:0] er);
        vec_t e;
        e.v = v; e.a = a; e.b = b; e.rr = rr; e.er = er;
        vt.push_back(e);
    endtask

    // Called at posedge+1: drive, check at negedge, update scoreboard, advance one cycle.
    task automatic cycle(input logic [3:0] v, input logic [19:0] a, input logic [19:0] b,
                         input logic rr, input logic [3:0] er, input string tag);
        req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
        @(negedge clk);
        chk({tag, ".req_ready"}, int'(req_ready), int'(er));
        chk({tag, ".rsp_valid"}, int'(rsp_valid), int'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".rsp_id"}, int'(rsp_id), int'(q[0].id));
            chk({tag, ".rsp_result"}, int'(rsp_result), int'(q[0].res));
            if (rr) void'(q.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            if (v[i] && er[i]) begin
                exp_t e;
                e.id  = 2'(i);
                e.res = prod(a[i*5 +: 5], b[i*5 +: 5]);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [19:0] fa, fb;
        fa = pk(9, 6, 4, 2);
        fb = pk(31, 17, 12, 5);

        add(4'b0100, pk(0, 3, 0, 0), pk(0, 7, 0, 0), 1'b1, 4'b0100);
        add(4'b0000, '0, '0, 1'b1, 4'b0000);
        add(4'b1111, fa, fb, 1'b1, 4'b1000);
        add(4'b1111, fa, fb, 1'b1, 4'b0001);
        add(4'b1111, fa, fb, 1'b1, 4'b0010);
        add(4'b1111, fa, fb, 1'b1, 4'b0100);
        add(4'b1111, fa, fb, 1'b1, 4'b1000);
        for (int i = 0; i < 5; i++) add(4'b1111, fa, fb, 1'b0, 4'b0000);
        add(4'b1111, fa, fb, 1'b1, 4'b0001);
        add(4'b0000, '0, '0, 1'b1, 4'b0000);
        add(4'b0000, '0, '0, 1'b1, 4'b0000);
        add(4'b0001, pk(0, 0, 0, 31), pk(0, 0, 0, 31), 1'b1, 4'b0001);
        add(4'b0010, pk(0, 0, 0, 0), pk(0, 0, 31, 0), 1'b1, 4'b0010);
        add(4'b0000, '0, '0, 1'b1, 4'b0000);
        add(4'b1010, pk(30, 0, 20, 0), pk(25, 0, 29, 0), 1'b1, 4'b1000);
        add(4'b1010, pk(30, 0, 20, 0), pk(25, 0, 29, 0), 1'b1, 4'b0010);
        add(4'b0000, '0, '0, 1'b1, 4'b0000);
        add(4'b0101, pk(0, 13, 0, 11), pk(0, 3, 0, 2), 1'b1, 4'b0100);
        add(4'b0001, pk(0, 13, 0, 11), pk(0, 3, 0, 2), 1'b1, 4'b0001);
        add(4'b0000, '0, '0, 1'b1, 4'b0000);

        reset_n = 1'b0; req_valid = 4'b1111; req_a = fa; req_b = fb; rsp_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset.req_ready", int'(req_ready), 0);
        chk("reset.rsp_valid", int'(rsp_valid), 0);
        chk("reset.rsp_id", int'(rsp_id), 0);
        chk("reset.rsp_result", int'(rsp_result), 0);
        req_valid = 4'b0000;
        reset_n = 1'b1;

        for (int i = 0; i < vt.size(); i++)
            cycle(vt[i].v, vt[i].a, vt[i].b, vt[i].rr, vt[i].er, $sformatf("vec%0d", i));

        // Reset while a result is pending and requester 3 keeps asking.
        cycle(4'b1000, pk(5, 0, 0, 0), pk(6, 0, 0, 0), 1'b1, 4'b1000, "rst_pre");
        cycle(4'b1000, pk(7, 0, 0, 0), pk(7, 0, 0, 0), 1'b0, 4'b0000, "rst_hold");
        reset_n = 1'b0;
        #1;
        chk("rst_async.rsp_valid", int'(rsp_valid), 0);
        chk("rst_async.rsp_result", int'(rsp_result), 0);
        chk("rst_async.rsp_id", int'(rsp_id), 0);
        chk("rst_async.req_ready", int'(req_ready), 0);
        q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        cycle(4'b1010, pk(3, 0, 4, 0), pk(3, 0, 5, 0), 1'b1, 4'b0010, "post_rst");
        cycle(4'b1010, pk(3, 0, 4, 0), pk(3, 0, 5, 0), 1'b1, 4'b1000, "post_rst2");
        cycle(4'b0000, '0, '0, 1'b1, 4'b0000, "drain");
        cycle(4'b0000, '0, '0, 1'b1, 4'b0000, "idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter ENTRY_SIZE, default 5: operand width in bits.
REQ-002 SHALL have parameter RESENTRY_SIZE, default 9: result width in bits.
REQ-003 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept.
REQ-008 SHALL have port req_a  input  NUM_REQ*ENTRY_SIZE  operand a; requester i occupies bits [i*ENTRY_SIZE +: ENTRY_SIZE].
REQ-009 SHALL have port req_b  input  NUM_REQ*ENTRY_SIZE  operand b; same packing as req_a.
REQ-010 SHALL have port rsp_valid  output  1  result register holds an undelivered product.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port rsp_id  output  clog2(NUM_REQ)  index of the requester that owns the result.
REQ-013 SHALL have port rsp_result  output  RESENTRY_SIZE  unsigned product.

Function
REQ-014 SHALL share one unsigned ENTRY_SIZE x ENTRY_SIZE multiplier among all requesters.
REQ-015 SHALL keep a round-robin pointer ptr; grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ... with wrap modulo NUM_REQ.
REQ-016 SHALL compute grant combinationally each cycle; at most one req_ready bit is high.
REQ-017 SHALL drive req_ready[i] = grant[i] AND (NOT rsp_valid OR rsp_ready).
REQ-018 A handshake is req_valid[i] AND req_ready[i] at a rising edge.
REQ-019 On a handshake, SHALL load rsp_result with the product, rsp_id with i, set rsp_valid=1, and set ptr=(i+1) mod NUM_REQ; latency is 1 cycle from handshake to rsp_valid.
REQ-020 SHALL leave ptr unchanged in any cycle without a handshake.
REQ-021 On rsp_valid AND rsp_ready with no new handshake, SHALL clear rsp_valid; rsp_result and rsp_id hold their last values.
REQ-022 On rsp_valid AND rsp_ready with a new handshake in the same cycle, SHALL load the new result with rsp_valid staying 1; this gives 1 result per cycle throughput.
REQ-023 While rsp_valid=1 and rsp_ready=0, SHALL hold rsp_result and rsp_id stable and drive all req_ready low.
REQ-024 SHALL take operand and requester state from registers or from the cycle's inputs only, never from a previously granted but unaccepted request; a requester dropping req_valid before the handshake loses nothing.
REQ-025 SHALL define the product as the full 2*ENTRY_SIZE-bit unsigned a*b, then narrow it to RESENTRY_SIZE per REQ-030/REQ-031.
REQ-026 SHALL give each continuously-valid requester a grant within NUM_REQ handshakes (no starvation).

Reset
REQ-027 On reset_n=0, SHALL asynchronously set rsp_valid=0, rsp_result=0, rsp_id=0 and ptr=0.
REQ-028 While reset_n=0, SHALL hold req_ready all 0.
REQ-029 A reset asserted with rsp_valid=1 SHALL discard the pending result; the first post-reset grant SHALL search from requester 0.

Configuration
REQ-030 With macro MULT_ARB_SAT_EN defined, a product exceeding 2^RESENTRY_SIZE-1 SHALL yield rsp_result = all ones.
REQ-031 Without MULT_ARB_SAT_EN, SHALL yield rsp_result = product mod 2^RESENTRY_SIZE (low bits); all other behaviour is identical.

Verification
REQ-032 Single request: req_valid=4'b0100, a=3, b=7, rsp_ready=1 -> req_ready=4'b0100; next cycle rsp_valid=1, rsp_id=2, rsp_result=21; ptr becomes 3.
REQ-033 Fairness: all four requesters held valid, rsp_ready=1 from reset -> rsp_id sequence 0,1,2,3,0, one result per cycle.
REQ-034 Backpressure: rsp_ready=0 after the first result -> rsp_valid, rsp_id and rsp_result stay stable and req_ready=0 for 5 cycles; on release, the next grant proceeds with no loss or duplication.
REQ-035 Overflow: a=31, b=31 -> rsp_result=511 with MULT_ARB_SAT_EN defined, 449 without; a=0, b=31 -> 0 in both builds.
REQ-036 Reset mid-operation: assert reset_n=0 while rsp_valid=1 and requester 3 is pending -> rsp_valid=0 at once; after release with requesters 1 and 3 valid, the first grant goes to 1.
